whitening_engine: RTL



---
 rtl/ble_whiten_pkg.sv | 60 ++++++
 rtl/whitening_engine_lfsr_step.sv | 27 ++
 rtl/whitening_engine.sv | 110 +++++++++++
 3 files changed

// File: rtl/ble_whiten_pkg.sv
// BLE data whitening helpers: polynomial taps, advertising channel seeds,
// and width-generic LFSR load / multi-step functions shared by the engine.
package ble_whiten_pkg;

    localparam int unsigned LFSR_MAX_W = 32;
    localparam int unsigned KEY_MAX_W  = 64;

    localparam logic [6:0] BLE_POLY_TAPS = 7'b0010000;  // x^7 + x^4 + 1

    localparam int unsigned BLE_ADV_CHANNEL_37 = 37;
    localparam int unsigned BLE_ADV_CHANNEL_38 = 38;
    localparam int unsigned BLE_ADV_CHANNEL_39 = 39;

    // Result of an n-step advance: key bit k is the MSB seen before step k.
    typedef struct packed {
        logic [KEY_MAX_W-1:0]  key;
        logic [LFSR_MAX_W-1:0] state;
    } lfsr_step_t;

    // s[0]=1, s[i]=seed[seed_w-i] for i=1..seed_w (channel bits reversed).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_load(
        input logic [LFSR_MAX_W-2:0] seed,
        input int unsigned           seed_w
    );
        logic [LFSR_MAX_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < int'(LFSR_MAX_W) - 1; i++) begin
            rev[i] = seed[int'(LFSR_MAX_W) - 2 - i];
        end
        // Shift so the reversed seed lands on stages 1..seed_w.
        return ((rev >> (LFSR_MAX_W - 1 - seed_w)) << 1) | LFSR_MAX_W'(1);
    endfunction

    // Advance a w-stage LFSR n times, collecting the key bit of each step.
    function automatic lfsr_step_t lfsr_step_n(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           w,
        input int unsigned           n
    );
        lfsr_step_t            res;
        logic [LFSR_MAX_W-1:0] st;
        logic [LFSR_MAX_W-1:0] width_mask;
        logic                  msb;
        res        = '0;
        st         = state;
        width_mask = (LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1);
        for (int unsigned k = 0; k < KEY_MAX_W; k++) begin
            if (k < n) begin
                msb        = |(st & (LFSR_MAX_W'(1) << (w - 1)));
                res.key[k] = msb;
                st = (((st << 1) | LFSR_MAX_W'(msb))
                      ^ ({LFSR_MAX_W{msb}} & taps & ~LFSR_MAX_W'(1))) & width_mask;
            end
        end
        res.state = st;
        return res;
    endfunction

endpackage

// File: rtl/whitening_engine_lfsr_step.sv
// Combinational DATA_WIDTH-step unroll of the whitening LFSR.
// Ports: state (current LFSR), key_c (per-bit key, bit 0 first on air),
//        next_state_c (LFSR after DATA_WIDTH steps).
module whitening_lfsr_step
    import ble_whiten_pkg::*;
#(
    parameter int unsigned        LFSR_W     = 7,
    parameter int unsigned        DATA_WIDTH = 8,
    parameter logic [LFSR_W-1:0]  TAP_MASK   = LFSR_W'(BLE_POLY_TAPS)
) (
    input  logic [LFSR_W-1:0]     state,
    output logic [DATA_WIDTH-1:0] key_c,
    output logic [LFSR_W-1:0]     next_state_c
);

    lfsr_step_t step_c;
    logic       unused_step_bits;

    always_comb begin
        step_c = lfsr_step_n(LFSR_MAX_W'(state), LFSR_MAX_W'(TAP_MASK), LFSR_W, DATA_WIDTH);
    end

    assign key_c            = step_c.key[DATA_WIDTH-1:0];
    assign next_state_c     = step_c.state[LFSR_W-1:0];
    assign unused_step_bits = ^step_c;

endmodule

// File: rtl/whitening_engine.sv
// BLE whitening / de-whitening engine, DATA_WIDTH bits per beat.
// Ports: clk, rst (async high); seed/seed_load (store channel, reload LFSR);
//        whiten_en (0 = bypass); in_* valid/ready/last input stream;
//        out_* registered output stream; bit_count (saturating bits whitened).
module whitening_engine
    import ble_whiten_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter int unsigned              SEED_WIDTH  = 6,
    parameter logic [SEED_WIDTH:0]      TAP_MASK    = (SEED_WIDTH+1)'(BLE_POLY_TAPS),
    parameter int unsigned              SEED_RESET  = BLE_ADV_CHANNEL_37,
    parameter int unsigned              AUTO_RELOAD = 1,
    parameter int unsigned              COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEED_WIDTH-1:0]  seed,
    input  logic                   seed_load,
    input  logic                   whiten_en,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] bit_count
);

    localparam int unsigned LFSR_W = SEED_WIDTH + 1;
    localparam logic [LFSR_MAX_W-1:0] RESET_STATE_FULL =
        lfsr_load((LFSR_MAX_W-1)'(SEED_RESET), SEED_WIDTH);
    localparam logic [LFSR_W-1:0]     RESET_STATE = RESET_STATE_FULL[LFSR_W-1:0];
    localparam logic [COUNT_WIDTH:0]  BEAT_BITS   = (COUNT_WIDTH+1)'(DATA_WIDTH);

    logic [SEED_WIDTH-1:0]  seed_q;
    logic [LFSR_W-1:0]      lfsr_q;
    logic [DATA_WIDTH-1:0]  key_c;
    logic [LFSR_W-1:0]      stepped_c;
    logic [LFSR_MAX_W-1:0]  load_new_c;
    logic [LFSR_MAX_W-1:0]  load_stored_c;
    logic                   unused_load_bits;
    logic                   accept_c;
    logic [COUNT_WIDTH:0]   count_sum_c;
    logic [COUNT_WIDTH-1:0] count_sat_c;

    // Keystream for the current beat and the LFSR state after it.
    whitening_lfsr_step #(
        .LFSR_W     (LFSR_W),
        .DATA_WIDTH (DATA_WIDTH),
        .TAP_MASK   (TAP_MASK)
    ) u_step (
        .state        (lfsr_q),
        .key_c        (key_c),
        .next_state_c (stepped_c)
    );

    // Handshake: a seed load blocks intake for its cycle.
    assign in_ready = !seed_load && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;

    // Load images for a new channel and for the stored channel (packet end).
    always_comb begin
        load_new_c    = lfsr_load((LFSR_MAX_W-1)'(seed), SEED_WIDTH);
        load_stored_c = lfsr_load((LFSR_MAX_W-1)'(seed_q), SEED_WIDTH);
    end
    assign unused_load_bits = ^{load_new_c, load_stored_c};

    // Saturating bit counter increment.
    assign count_sum_c = {1'b0, bit_count} + BEAT_BITS;
    assign count_sat_c = count_sum_c[COUNT_WIDTH] ? '1 : count_sum_c[COUNT_WIDTH-1:0];

    // Seed, LFSR and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q    <= SEED_WIDTH'(SEED_RESET);
            lfsr_q    <= RESET_STATE;
            bit_count <= '0;
        end else if (seed_load) begin
            seed_q    <= seed;
            lfsr_q    <= load_new_c[LFSR_W-1:0];
            bit_count <= '0;
        end else if (accept_c) begin
            if ((AUTO_RELOAD != 0) && in_last) begin
                lfsr_q    <= load_stored_c[LFSR_W-1:0];
                bit_count <= '0;
            end else if (whiten_en) begin
                lfsr_q    <= stepped_c;
                bit_count <= count_sat_c;
            end
        end
    end

    // Registered output stage; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept_c) begin
            out_data  <= whiten_en ? (in_data ^ key_c) : in_data;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
